uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Transmit-side UART controller driving the board's `rs_tx` pin in the system clock domain. Buffers bytes from the CPU bus in a small FIFO, generates its own baud timing from a clock divider, and serialises each byte as an 8N1 frame (start, 8 data LSB-first, stop). Frames are sent back-to-back while the FIFO holds data, with no idle gap between them.

## Interface

- `CLK_FREQ`, 50_000_000, clock frequency in Hz.
- `BAUD`, 115200, line rate in bit/s; `DIV = CLK_FREQ / BAUD` (integer truncation), which must be ≥ 2.
- `DEPTH`, 16, FIFO depth in bytes; power of two, ≥ 2; `AW = $clog2(DEPTH)`.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue strobe, one byte per cycle while high.
- `full`  out  1  FIFO holds DEPTH bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  AW+1  current FIFO occupancy, 0..DEPTH.
- `overflow`  out  1  one-cycle pulse when a write is dropped.
- `busy`  out  1  high whenever the state is not IDLE.
- `tx`  out  1  serial line; registered, idle high.

## Operation

- FIFO: circular buffer with AW-bit read and write pointers that wrap modulo DEPTH, plus the `count` register. `full` and `empty` decode from `count`.
- Write:
  - `wr_en && !full` stores `wr_data` at the write pointer and advances the pointer.
  - `wr_en && full` drops the byte and pulses `overflow` on the next cycle. This holds even if a pop happens in the same cycle.
- Pop: the FSM reads the head byte into a 8-bit shift register and advances the read pointer.
  - A simultaneous accepted write and pop leaves `count` unchanged.
- Baud counter: counts 0..DIV-1 while not IDLE. It is held at 0 in IDLE. Each bit lasts exactly DIV cycles.
- FSM states and transitions:
  - IDLE → START when `!empty`: pop in the same cycle, baud counter reset to 0.
  - START (tx=0) → DATA at counter wrap; bit index reset to 0.
  - DATA (tx = shift[0]): at counter wrap, shift right and increment the bit index. After bit 7, go to STOP.
  - STOP (tx=1), at counter wrap: if `!empty`, pop and go to START; otherwise go to IDLE.
- `tx` is the registered output of the state and shift register. It changes only on bit boundaries.
- Reset: both pointers, `count`, bit index and baud counter go to 0; state goes to IDLE.
  - Reset values: `tx`=1, `busy`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0.
  - Reset mid-frame aborts the frame: `tx` is 1 after the reset edge and FIFO contents are discarded.

## Timing

- A write at edge k gives `count`=1 after edge k.
- The FSM sees `!empty` at edge k+1, pops, and `tx` falls after edge k+1. Write-to-start-bit latency is 1 cycle after `count` updates.
- Frame length is exactly 10·DIV cycles: start 1·DIV, data 8·DIV, stop 1·DIV.
- Back-to-back frames:
  - The next start bit begins on the cycle immediately after the last stop-bit cycle.
  - Frame period is 10·DIV cycles; no extra idle cycle.
- `busy` rises with the start bit. It falls after the last stop-bit cycle only when the FIFO is empty.
- Writes are accepted every cycle, independent of FSM state. `full` reflects the `count` registered at the previous edge.

## Test plan

Parameters for all scenarios unless stated: CLK_FREQ=1000, BAUD=100 (DIV=10), DEPTH=4.

- **Reset values:** reset, then release → `tx`=1, `busy`=0, `empty`=1, `count`=0 held for 50 cycles.
- **Single byte:** write 0xA5 → `tx` goes low 1 cycle after `count`=1.
  - Sampled mid-bit, the line reads 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 10 cycles.
  - `busy` falls after 100 cycles.
- **Back-to-back:** write 0x00 then 0xFF on consecutive cycles → two frames totalling 200 cycles with no idle cycle between the stop bit and the second start bit; `empty`=1 at the end.
- **Overflow:** with the FSM held busy, write 6 bytes in consecutive cycles 0x10..0x15.
  - The first byte is popped immediately; `full` asserts.
  - Exactly one `overflow` pulse, on the 6th write.
  - 0x10..0x14 are transmitted in order; 0x15 never appears.
- **Pointer wrap:** stream 12 bytes with enough gaps between writes to avoid overflow → all 12 transmitted in order, `count` never exceeds 4.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 3 of a frame with 2 bytes queued → `tx`=1 after the reset edge and `count`=0. After release, no frame is sent.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: byte-write bus and FIFO status between the CPU side (master) and uart_tx_ctrl (slave)
//   wr_data/wr_en: enqueue request; full/empty/count/overflow: FIFO status back to the writer
interface uart_tx_ctrl_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] wr_data;
  logic wr_en;
  logic full;
  logic empty;
  logic [AW:0] count;
  logic overflow;
  modport master(output wr_data, wr_en, input full, empty, count, overflow);
  modport slave(input wr_data, wr_en, output full, empty, count, overflow);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: FIFO-buffered 8N1 UART transmitter with back-to-back frames
//   clk, rst_n (sync, active-low); bus: write port and FIFO status; busy: frame in progress; tx: serial line
module uart_tx_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int DEPTH = 16
) (
  input logic clk,
  input logic rst_n,
  uart_tx_ctrl_if.slave bus,
  output logic busy,
  output logic tx
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, ovf_q, ovf_d;
  logic full, empty, wrap, wr_acc, pop;
  always_comb begin
    full = count_q == (AW+1)'(DEPTH);
    empty = count_q == '0;
    wrap = baud_q == CW'(DIV - 1);
    wr_acc = bus.wr_en && !full;
    // a pop happens on leaving IDLE or at the end of a stop bit, so frames chain with no gap
    pop = !empty && (state_q == IDLE || (state_q == STOP && wrap));
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + (AW+1)'(wr_acc) - (AW+1)'(pop);
    ovf_d = bus.wr_en && full;
    baud_d = (state_q == IDLE || wrap) ? '0 : baud_q + 1'b1;
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: state_d = pop ? START : IDLE;
      START: if (wrap) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (wrap) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      default: if (wrap) state_d = pop ? START : IDLE;
    endcase
    if (pop) shift_d = mem_q[rd_ptr_q];
    // tx is registered from the next state so it only moves on bit boundaries
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk) if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.count = count_q;
  assign bus.overflow = ovf_q;
  assign busy = state_q != IDLE;
  assign tx = tx_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed scoreboard bench for uart_tx_ctrl (DIV=10, DEPTH=4)
module tb_uart_tx_ctrl;
  logic clk, rst_n, busy, tx;
  int checks, errors, n, mx, ov;
  logic [7:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [9:0] mon_f;
  logic mon_ab;
  logic [7:0] b;
  uart_tx_ctrl_if #(.DEPTH(4)) bif();
  uart_tx_ctrl #(.CLK_FREQ(1000), .BAUD(100), .DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bif),
    .busy(busy),
    .tx(tx)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // line monitor: a 0 seen at a negedge is the first start-bit cycle; sample mid-bit every 10 cycles
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && tx === 1'b0) begin
      mon_f = '0;
      mon_ab = 1'b0;
      for (int i = 1; i <= 94; i++) begin
        @(negedge clk);
        if (rst_n !== 1'b1) mon_ab = 1'b1;
        if (i % 10 == 4) mon_f[i/10] = tx;
      end
      if (!mon_ab) got_q.push_back(mon_f);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic wr(input logic [7:0] d);
    bif.wr_data = d;
    bif.wr_en = 1'b1;
    @(negedge clk);
    bif.wr_en = 1'b0;
  endtask
  task automatic drain(input string tag);
    logic [7:0] e;
    logic [9:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 10'h3ff;
      chk(tag, 32'(g), 32'({1'b1, e, 1'b0}));
    end
    chk({tag, " extra frames"}, got_q.size(), 0);
  endtask
  task automatic busy_len(input int bound);
    n = 0;
    while (busy && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bif.wr_en = 1'b0;
    bif.wr_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("reset idle", {tx, busy, bif.empty, bif.full, bif.count, bif.overflow}, 8'b1010_0000);
    end
    wr(8'hA5);
    exp_q.push_back(8'hA5);
    chk("single count", bif.count, 1);
    chk("single tx before start", tx, 1);
    @(negedge clk);
    chk("single start bit", {tx, busy}, 2'b01);
    busy_len(300);
    chk("single frame length", n, 100);
    drain("single frame");
    wr(8'h00);
    wr(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    busy_len(400);
    chk("b2b busy length", n, 200);
    chk("b2b empty", bif.empty, 1);
    drain("b2b frame");
    for (int i = 0; i < 6; i++) begin
      wr(8'h10 + 8'(i));
      if (i < 5) exp_q.push_back(8'h10 + 8'(i));
      chk("ovf pulse", bif.overflow, i == 5);
    end
    chk("ovf full count", {bif.full, bif.count}, 4'b1100);
    @(negedge clk);
    chk("ovf pulse end", bif.overflow, 0);
    busy_len(1000);
    chk("ovf busy length", n, 495);
    drain("ovf frame");
    mx = 0;
    ov = 0;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      wr(b);
      exp_q.push_back(b);
      for (int j = 0; j < 79; j++) begin
        if (int'(bif.count) > mx) mx = int'(bif.count);
        if (bif.overflow) ov++;
        @(negedge clk);
      end
    end
    busy_len(2000);
    chk("wrap no timeout", n < 2000, 1);
    chk("wrap max count", mx <= 4, 1);
    chk("wrap no overflow", ov, 0);
    drain("wrap frame");
    wr(8'h3C);
    wr(8'hC3);
    wr(8'h5A);
    repeat (44) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset state", {tx, busy, bif.count}, 5'b10000);
    chk("midreset empty", bif.empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) n++;
    end
    chk("midreset line quiet", n, 0);
    chk("midreset count", bif.count, 0);
    drain("midreset frame");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
